// File: rtl/spi_frame_controller.sv
// SPI write-frame sequencer: oversamples raw SPI pins on clk, frames cs_n-delimited
// transactions, validates them and issues one valid/ready write per accepted frame.
module spi_frame_controller #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       copi,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_done,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVR  = CNT_W'(FRAME_BITS + 1);
  localparam logic [6:0]       ADDR_MAX = 7'(MAX_ADDR);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, copi_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, cs_n_s, copi_s, sclk_rise;

  state_t                  state_q;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [FRAME_BITS-1:0]   shreg_q;
  logic                    wr_valid_q, frame_done_q, busy_q;
  logic [6:0]              wr_addr_q;
  logic [7:0]              wr_data_q, err_q;
  logic [6:0]              addr_field;
  logic                    slot_blocked;

  // cs_n synchronizer resets high so a reset never looks like a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      copi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s       = sclk_sync_q[SYNC_STAGES-1];
  assign cs_n_s       = cs_sync_q[SYNC_STAGES-1];
  assign copi_s       = copi_sync_q[SYNC_STAGES-1];
  assign sclk_rise    = sclk_s & ~sclk_prev_q;
  assign addr_field   = shreg_q[FRAME_BITS-2 -: 7];
  assign slot_blocked = wr_valid_q & ~wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (wr_valid_q && wr_ready) wr_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (!cs_n_s) begin
            state_q   <= SHIFT;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            busy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          // a final edge coincident with cs_n rising is still captured
          if (sclk_rise) begin
            shreg_q <= {shreg_q[FRAME_BITS-2:0], copi_s};
            if (bit_cnt_q != CNT_OVR) bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          if (cs_n_s) begin
            state_q      <= CHECK;
            frame_done_q <= 1'b1;
          end
        end
        CHECK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (bit_cnt_q != CNT_FULL) begin
            if (err_q != 8'hFF) err_q <= err_q + 1'b1;
          end else if (!shreg_q[FRAME_BITS-1]) begin
            // read frames are ignored without counting an error
          end else if (addr_field > ADDR_MAX || slot_blocked) begin
            if (err_q != 8'hFF) err_q <= err_q + 1'b1;
          end else begin
            wr_valid_q <= 1'b1;
            wr_addr_q  <= addr_field;
            wr_data_q  <= shreg_q[7:0];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_valid   = wr_valid_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_spi_frame_controller.sv
// Directed bench for spi_frame_controller: drives SPI frames on the raw pins and
// checks write requests, frame pulses, error counting, latency and reset abort.
module tb_spi_frame_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0, cs_n = 1'b1, copi = 1'b0;
  logic       wr_valid, wr_ready = 1'b0;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_done, busy;
  logic [7:0] err_count;

  int total = 0, bad = 0;
  int cyc = 0;
  int fd_cnt = 0, fd_cyc = 0, vcyc = 0, vrise_cyc = 0, drops = 0, hs_cnt = 0;
  logic [6:0] hs_addr = '0;
  logic [7:0] hs_data = '0;
  logic prev_v = 1'b0;
  int cs_rise_cyc = 0;
  int h, f, d;

  spi_frame_controller #(.SYNC_STAGES(2), .FRAME_BITS(16), .MAX_ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .copi(copi),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // observe outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
    if (wr_valid) vcyc++;
    if (wr_valid && !prev_v) vrise_cyc = cyc;
    if (!wr_valid && prev_v) drops++;
    if (wr_valid && wr_ready) begin hs_cnt++; hs_addr = wr_addr; hs_data = wr_data; end
    prev_v = wr_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic spi_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = v[i];
      wait_clk(2);
      sclk = 1'b1;
      wait_clk(2);
      sclk = 1'b0;
    end
    wait_clk(2);
  endtask

  // pulse_rdy raises wr_ready only for the cycle the FSM spends in CHECK
  task automatic cs_high(input bit pulse_rdy);
    cs_n = 1'b1;
    cs_rise_cyc = cyc;
    if (pulse_rdy) begin
      wait_clk(3);
      wr_ready = 1'b1;
      chk("check_cycle_frame_done", {31'd0, frame_done}, 32'd1);
      wait_clk(1);
      wr_ready = 1'b0;
      wait_clk(3);
    end else begin
      wait_clk(6);
    end
  endtask

  task automatic frame(input logic [31:0] v, input int n);
    cs_low();
    spi_bits(v, n);
    cs_high(1'b0);
  endtask

  initial begin
    wait_clk(3);
    chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    chk("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {24'd0, err_count}, 32'd0);
    rst_n = 1'b1;
    wr_ready = 1'b1;
    wait_clk(2);

    // valid write addr 2 data 0xA5
    f = fd_cnt; h = hs_cnt; vcyc = 0;
    cs_low();
    chk("busy_in_shift", {31'd0, busy}, 32'd1);
    spi_bits(32'h82A5, 16);
    cs_high(1'b0);
    chk("w1_hs_count", hs_cnt - h, 1);
    chk("w1_addr", {25'd0, hs_addr}, 32'd2);
    chk("w1_data", {24'd0, hs_data}, 32'hA5);
    chk("w1_valid_cycles", vcyc, 1);
    chk("w1_frame_done", fd_cnt - f, 1);
    chk("w1_done_latency", fd_cyc - cs_rise_cyc, 3);
    chk("w1_valid_latency", vrise_cyc - cs_rise_cyc, 4);
    chk("w1_err", {24'd0, err_count}, 32'd0);
    chk("w1_busy_idle", {31'd0, busy}, 32'd0);

    // bad address, short frame, long frame
    f = fd_cnt; h = hs_cnt;
    frame(32'h853C, 16);
    chk("badaddr_err", {24'd0, err_count}, 32'd1);
    chk("badaddr_done", fd_cnt - f, 1);
    frame(32'h4152, 15);
    frame(32'h1054A, 17);
    chk("len_err", {24'd0, err_count}, 32'd3);
    chk("len_no_req", hs_cnt - h, 0);
    chk("len_done", fd_cnt - f, 3);

    // read frame is silent
    f = fd_cnt;
    frame(32'h01FF, 16);
    chk("read_done", fd_cnt - f, 1);
    chk("read_no_req", hs_cnt - h, 0);
    chk("read_err", {24'd0, err_count}, 32'd3);

    // backpressure: second write dropped
    wr_ready = 1'b0;
    frame(32'h8011, 16);
    frame(32'h8122, 16);
    chk("bp_valid_held", {31'd0, wr_valid}, 32'd1);
    chk("bp_addr", {25'd0, wr_addr}, 32'd0);
    chk("bp_data", {24'd0, wr_data}, 32'h11);
    chk("bp_err", {24'd0, err_count}, 32'd4);
    chk("bp_no_hs", hs_cnt - h, 0);
    wr_ready = 1'b1;
    wait_clk(3);
    chk("bp_release_hs", hs_cnt - h, 1);
    chk("bp_release_data", {24'd0, hs_data}, 32'h11);
    chk("bp_valid_low", {31'd0, wr_valid}, 32'd0);

    // handshake in the same CHECK cycle as a new load
    wr_ready = 1'b0;
    frame(32'h8011, 16);
    h = hs_cnt; d = drops;
    cs_low();
    spi_bits(32'h8480, 16);
    cs_high(1'b1);
    chk("swap_hs", hs_cnt - h, 1);
    chk("swap_old_data", {24'd0, hs_data}, 32'h11);
    chk("swap_no_bubble", drops - d, 0);
    chk("swap_valid", {31'd0, wr_valid}, 32'd1);
    chk("swap_addr", {25'd0, wr_addr}, 32'd4);
    chk("swap_data", {24'd0, wr_data}, 32'h80);
    wr_ready = 1'b1;
    wait_clk(3);
    chk("swap_final_addr", {25'd0, hs_addr}, 32'd4);
    chk("swap_valid_low", {31'd0, wr_valid}, 32'd0);
    chk("swap_err", {24'd0, err_count}, 32'd4);

    // reset mid-frame with a write pending
    wr_ready = 1'b0;
    frame(32'h8011, 16);
    h = hs_cnt;
    cs_low();
    spi_bits(32'h83, 8);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'd0, wr_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_err", {24'd0, err_count}, 32'd0);
    chk("abort_addr", {25'd0, wr_addr}, 32'd0);
    chk("abort_data", {24'd0, wr_data}, 32'd0);
    cs_n = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wr_ready = 1'b1;
    wait_clk(3);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    frame(32'h830F, 16);
    chk("post_hs", hs_cnt - h, 1);
    chk("post_addr", {25'd0, hs_addr}, 32'd3);
    chk("post_data", {24'd0, hs_data}, 32'h0F);
    chk("post_err", {24'd0, err_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/spi_frame_controller.md
Name: spi_frame_controller

Overview:
Clock-domain sequencer for the SPI register interface. It oversamples the raw SPI pins on clk, frames each cs_n-delimited transaction, and validates bit count, the write flag and the address. Each valid write is issued as one valid/ready write request to the register bank that drives the PWM/output-enable registers. The block replaces sampling on sclk, so all register updates are synchronous to clk.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each of sclk, cs_n and copi (minimum 2).
- FRAME_BITS, 16, exact bits per frame: 1 R/W bit, 7 address bits, 8 data bits, MSB first.
- MAX_ADDR, 4, highest writable address (0..MAX_ADDR).

Ports:
- clk  in  1  system clock, at least 4x the sclk frequency.
- rst_n  in  1  reset, asynchronous, active-low.
- sclk  in  1  SPI clock, asynchronous to clk.
- cs_n  in  1  SPI chip select, active-low, asynchronous.
- copi  in  1  SPI serial data in, asynchronous.
- wr_valid  out  1  write request pending.
- wr_ready  in  1  register bank accepts the request.
- wr_addr  out  7  write address.
- wr_data  out  8  write data.
- frame_done  out  1  one-cycle pulse per completed frame, valid or not.
- busy  out  1  high while the FSM is not in IDLE.
- err_count  out  8  saturating count of rejected frames.

Behaviour:
- Reset (asynchronous): all synchronizer flops reset to 1 for cs_n and 0 for sclk and copi. State IDLE, bit_cnt 0, shift register 0. Outputs after reset: wr_valid 0, wr_addr 0, wr_data 0, frame_done 0, busy 0, err_count 0.
- Reset asserted mid-frame or with a write pending: the frame is aborted and the pending request is discarded.
- Synchronisation and edges: sclk_s, cs_n_s and copi_s are the synchronized signals. sclk_rise = sclk_s & ~sclk_prev, where sclk_prev is sclk_s delayed one cycle.
- FSM states: IDLE, SHIFT, CHECK.
- IDLE: when cs_n_s is 0, go to SHIFT, clear bit_cnt and the shift register.
- SHIFT, on each sclk_rise:
  - shreg <= {shreg[FRAME_BITS-2:0], copi_s}.
  - bit_cnt increments and saturates at FRAME_BITS+1 (overrun marker).
  - The shift register keeps shifting beyond FRAME_BITS, but the frame is rejected in CHECK.
- SHIFT, when cs_n_s goes to 1: go to CHECK.
  - If sclk_rise occurs in the same cycle, that bit is shifted in first.
- CHECK lasts exactly one cycle, then returns to IDLE. frame_done pulses during CHECK. Checks in priority order:
  1. bit_cnt != FRAME_BITS: reject.
  2. shreg[15] == 0 (read): discard silently, with no error and no request.
  3. shreg[14:8] > MAX_ADDR: reject.
  4. Output slot busy (wr_valid=1 and wr_ready=0 in this cycle): reject (dropped).
  5. Otherwise load wr_addr=shreg[14:8] and wr_data=shreg[7:0], and set wr_valid=1 from the next cycle.
- Reject action: err_count increments by 1 and saturates at 255.
- Output slot: a depth-1 buffer.
  - wr_valid stays high and wr_addr/wr_data stay stable until the cycle in which wr_valid & wr_ready are both high; wr_valid then drops the next cycle.
  - If the handshake and a new load occur in the same CHECK cycle, the new request is loaded and wr_valid stays high with no bubble.
- Latency: a valid frame's cs_n pin rise reaches cs_n_s after SYNC_STAGES cycles. The FSM enters CHECK on the next clk and wr_valid asserts 1 clk after that, i.e. SYNC_STAGES+2 clk after the edge is sampled.
- Glitch or empty frame (cs_n low with no sclk edges): bit_cnt=0, so it is rejected and counted.
- A new cs_n fall during CHECK is handled from IDLE on the next cycle. Since cs_n high lasts at least 2 clk after synchronisation, no bit is lost.
- busy=1 in SHIFT and CHECK.

Test Plan:
- Write frame 0x82,0xA5 (addr 2, data 0xA5) with wr_ready tied 1 -> one wr_valid cycle with wr_addr=2, wr_data=0xA5; frame_done pulses once; err_count=0.
- Write to addr 0x05, data 0x3C -> no wr_valid, frame_done pulse, err_count=1. Then 15-bit and 17-bit frames -> err_count=3, no request.
- Read frame 0x01,0xFF -> frame_done pulse, no wr_valid, err_count unchanged.
- wr_ready held 0, then frames (addr 0, data 0x11) and (addr 1, data 0x22) -> wr_valid held with addr 0 and data 0x11 throughout; second frame dropped, err_count +1. Release wr_ready -> single handshake, then wr_valid=0.
- wr_ready pulsed in the exact CHECK cycle of a following valid frame (addr 4, data 0x80) -> wr_valid continuous, outputs switch to addr 4, data 0x80.
- rst_n asserted after 8 bits of a frame -> all outputs 0 and state IDLE. A full valid frame afterwards (addr 3, data 0x0F) is accepted normally.
